// File: rtl/i2c_reg_bank.sv
// Register bank behind an I2C slave: I2C and fabric write ports, plus a read-fetch FSM that
// snapshots one register and presents it with a ready pulse the slave can edge-detect.
module i2c_reg_bank #(
  parameter int unsigned         NUM_REGS  = 16,
  parameter logic [7:0]          DEVICE_ID = 8'hA5,
  parameter logic [NUM_REGS-1:0] RO_MASK   = 16'h0001,
  parameter int unsigned         READY_W   = 2
) (
  input  logic                  mod_clk,
  input  logic                  mod_rst,
  input  logic [7:0]            i2c_reg_addr,
  input  logic [7:0]            i2c_data_out,
  input  logic                  i2c_data_transfer_dir,
  input  logic                  i2c_data_transfer_done,
  input  logic                  i2c_reg_addr_changed,
  output logic [7:0]            i2c_data_in,
  output logic                  i2c_reg_data_ready,
  input  logic                  user_wr_en,
  input  logic [7:0]            user_wr_addr,
  input  logic [7:0]            user_wr_data,
  output logic [NUM_REGS*8-1:0] reg_flat,
  output logic [NUM_REGS-1:0]   reg_wr_strobe,
  output logic                  i2c_wr_err
);

  localparam int unsigned AW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [2:0]  LastCnt = 3'(READY_W - 1);

  typedef enum logic [1:0] {StIdle, StGap, StFetch, StHold} rd_state_e;

  logic [7:0]          regs_q [NUM_REGS];
  logic [7:0]          regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] strobe_q, strobe_d;
  logic                wr_err_q, wr_err_d;
  rd_state_e           state_q, state_d;
  logic [7:0]          raddr_q, raddr_d;
  logic [7:0]          din_q, din_d;
  logic                ready_q, ready_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [7:0]          rd_data;
  logic                i2c_in_range, user_in_range;

  assign i2c_in_range  = 32'(i2c_reg_addr) < NUM_REGS;
  assign user_in_range = 32'(user_wr_addr) < NUM_REGS;

  // User write is applied last so it wins over a same-cycle I2C write to the same register.
  always_comb begin
    regs_d   = regs_q;
    strobe_d = '0;
    wr_err_d = 1'b0;
    if (i2c_data_transfer_done && !i2c_data_transfer_dir) begin
      if (i2c_in_range && !RO_MASK[i2c_reg_addr[AW-1:0]]) begin
        regs_d[i2c_reg_addr[AW-1:0]]   = i2c_data_out;
        strobe_d[i2c_reg_addr[AW-1:0]] = 1'b1;
      end else begin
        wr_err_d = 1'b1;
      end
    end
    if (user_wr_en && user_in_range) begin
      regs_d[user_wr_addr[AW-1:0]] = user_wr_data;
    end
  end

  always_comb begin
    rd_data = 8'hFF;
    if (32'(raddr_q) < NUM_REGS) begin
      rd_data = regs_q[raddr_q[AW-1:0]];
    end
  end

  // A new address during FETCH/HOLD goes through GAP so ready always shows a fresh rising edge.
  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    din_d   = din_q;
    ready_d = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (i2c_reg_addr_changed) begin
          raddr_d = i2c_reg_addr;
          state_d = StFetch;
        end
      end
      StGap: begin
        if (i2c_reg_addr_changed) begin
          raddr_d = i2c_reg_addr;
        end else begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (i2c_reg_addr_changed) begin
          raddr_d = i2c_reg_addr;
          state_d = StGap;
        end else begin
          din_d   = rd_data;
          ready_d = 1'b1;
          cnt_d   = '0;
          state_d = StHold;
        end
      end
      StHold: begin
        if (i2c_reg_addr_changed) begin
          raddr_d = i2c_reg_addr;
          state_d = StGap;
        end else if (cnt_q == LastCnt) begin
          state_d = StIdle;
        end else begin
          ready_d = 1'b1;
          cnt_d   = cnt_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge mod_clk or posedge mod_rst) begin
    if (mod_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == 0) ? DEVICE_ID : 8'h00;
      end
      strobe_q <= '0;
      wr_err_q <= 1'b0;
      state_q  <= StIdle;
      raddr_q  <= 8'h00;
      din_q    <= 8'h00;
      ready_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      regs_q   <= regs_d;
      strobe_q <= strobe_d;
      wr_err_q <= wr_err_d;
      state_q  <= state_d;
      raddr_q  <= raddr_d;
      din_q    <= din_d;
      ready_q  <= ready_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    reg_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_flat[8*i +: 8] = regs_q[i];
    end
  end

  assign i2c_data_in        = din_q;
  assign i2c_reg_data_ready = ready_q;
  assign reg_wr_strobe      = strobe_q;
  assign i2c_wr_err         = wr_err_q;

endmodule
